stopwatch_ctrl: RTL and testbench

Run/pause/lap/clear controller for the 4-digit BCD stopwatch display, format M:SS.t. The block owns the timebase prescaler and sequences it with a 3-state FSM. It drives a cascaded BCD counter and exposes a live or lap-frozen digit set to the display mux. Button inputs arrive already debounced as single-cycle synchronous pulses.

---
 rtl/stopwatch_pkg.sv | 35 +++
 rtl/tick_prescaler.sv | 38 +++
 rtl/stopwatch_ctrl.sv | 124 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the M:SS.t stopwatch controller: FSM state
// encoding, BCD digit limits, the default timebase divisor and a
// saturating-free BCD digit step helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [3:0] TENTHS_MAX   = 4'd9;
  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_MAX      = 4'd9;

  // 100 MHz clock -> 10 Hz tick
  localparam int unsigned DEFAULT_TICK_DIV = 10_000_000;

  // Displayed/live time value, most significant digit first
  typedef struct packed {
    logic [3:0] min;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
  } bcd_time_t;

  // Next value of one digit; anything at or above the limit wraps to 0 so a
  // digit can never leave its legal range.
  function automatic logic [3:0] digit_step(input logic [3:0] d,
                                            input logic [3:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Timebase prescaler: counts clk_in cycles while en is high and flags the
// last cycle of each TICK_DIV-cycle period.
//   clk_in  : system clock
//   reset   : asynchronous, active-high
//   en      : count enable (held value when low)
//   clr     : synchronous clear, overrides en
//   tick_en : combinational, high when en and count is at TICK_DIV-1
//   count   : current prescaler phase
module tick_prescaler
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV,
  parameter int unsigned PRESC_W  = 24
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  output logic               tick_en,
  output logic [PRESC_W-1:0] count
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_DIV - 1);

  assign tick_en = en && (count == LAST);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) count <= '0;
      else               count <= count + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear controller for a 4-digit BCD stopwatch (M:SS.t).
// Owns the timebase prescaler, the IDLE/RUN/PAUSE FSM, the cascaded BCD
// counter, the lap snapshot and the display mux.
//   clk_in, reset          : clock, asynchronous active-high reset
//   start_stop, lap, clear : single-cycle debounced button pulses
//   disp_*                 : displayed digits (lap snapshot or live count)
//   running, paused        : decoded FSM state
//   lap_hold               : display frozen on snapshot
//   tick                   : 1-cycle pulse per counted 0.1 s
//   overflow               : 1-cycle pulse on 9:59.9 -> 0:00.0
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV,
  parameter int unsigned PRESC_W  = 24
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] disp_tenths,
  output logic [3:0] disp_sec_ones,
  output logic [3:0] disp_sec_tens,
  output logic [3:0] disp_min,
  output logic       running,
  output logic       paused,
  output logic       lap_hold,
  output logic       tick,
  output logic       overflow
);

  state_t    state;
  bcd_time_t live;
  bcd_time_t snapshot;
  bcd_time_t live_inc;
  bcd_time_t disp;
  logic      tick_en;
  logic      full_wrap;

  // Prescaler phase is only of interest when probing the design.
  logic [PRESC_W-1:0] presc_count_unused;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .PRESC_W  (PRESC_W)
  ) u_presc (
    .clk_in  (clk_in),
    .reset   (reset),
    .en      (state == RUN),
    .clr     (clear),
    .tick_en (tick_en),
    .count   (presc_count_unused)
  );

  // BCD cascade: each digit advances only when every lower digit wraps.
  always_comb begin
    logic t_wrap, so_wrap, st_wrap, m_wrap;
    t_wrap  = (live.tenths   >= TENTHS_MAX);
    so_wrap = (live.sec_ones >= SEC_ONES_MAX);
    st_wrap = (live.sec_tens >= SEC_TENS_MAX);
    m_wrap  = (live.min      >= MIN_MAX);

    live_inc          = live;
    live_inc.tenths   = digit_step(live.tenths, TENTHS_MAX);
    if (t_wrap)
      live_inc.sec_ones = digit_step(live.sec_ones, SEC_ONES_MAX);
    if (t_wrap && so_wrap)
      live_inc.sec_tens = digit_step(live.sec_tens, SEC_TENS_MAX);
    if (t_wrap && so_wrap && st_wrap)
      live_inc.min = digit_step(live.min, MIN_MAX);
    full_wrap = t_wrap && so_wrap && st_wrap && m_wrap;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      live     <= '0;
      snapshot <= '0;
      lap_hold <= 1'b0;
      tick     <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      live     <= '0;
      snapshot <= '0;
      lap_hold <= 1'b0;
      tick     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tick     <= tick_en;
      overflow <= tick_en && full_wrap;
      if (tick_en) live <= live_inc;

      // Snapshot captures the pre-edge count, even if a tick lands now.
      if (lap) begin
        if (lap_hold) begin
          lap_hold <= 1'b0;
        end else if (state == RUN) begin
          snapshot <= live;
          lap_hold <= 1'b1;
        end
      end

      if (start_stop) begin
        case (state)
          IDLE:    state <= RUN;
          RUN:     state <= PAUSE;
          PAUSE:   state <= RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign disp          = lap_hold ? snapshot : live;
  assign disp_tenths   = disp.tenths;
  assign disp_sec_ones = disp.sec_ones;
  assign disp_sec_tens = disp.sec_tens;
  assign disp_min      = disp.min;
  assign running       = (state == RUN);
  assign paused        = (state == PAUSE);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboarded bench for stopwatch_ctrl with TICK_DIV=4.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int PW = 3;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       start_stop = 1'b0;
  logic       lap = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] disp_tenths, disp_sec_ones, disp_sec_tens, disp_min;
  logic       running, paused, lap_hold, tick, overflow;

  stopwatch_ctrl #(.TICK_DIV(TD), .PRESC_W(PW)) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .start_stop    (start_stop),
    .lap           (lap),
    .clear         (clear),
    .disp_tenths   (disp_tenths),
    .disp_sec_ones (disp_sec_ones),
    .disp_sec_tens (disp_sec_tens),
    .disp_min      (disp_min),
    .running       (running),
    .paused        (paused),
    .lap_hold      (lap_hold),
    .tick          (tick),
    .overflow      (overflow)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: live time held as an integer count of tenths
  int m_state;   // 0 idle, 1 run, 2 pause
  int m_presc;
  int m_live;
  int m_snap;
  bit m_hold, m_tick, m_ovf;

  logic [20:0] sb_q[$];

  function automatic logic [15:0] to_bcd(input int v);
    int ds;
    ds = v / 10;
    return {4'(ds / 60), 4'((ds % 60) / 10), 4'(ds % 10), 4'(v % 10)};
  endfunction

  function automatic logic [20:0] model_out();
    return {to_bcd(m_hold ? m_snap : m_live), m_state == 1, m_state == 2,
            m_hold, m_tick, m_ovf};
  endfunction

  function automatic logic [20:0] dut_out();
    return {disp_min, disp_sec_tens, disp_sec_ones, disp_tenths,
            running, paused, lap_hold, tick, overflow};
  endfunction

  task automatic model_reset();
    m_state = 0; m_presc = 0; m_live = 0; m_snap = 0;
    m_hold = 0; m_tick = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit ss, input bit lp, input bit clr);
    bit tk;
    if (clr) begin
      model_reset();
      return;
    end
    tk = (m_state == 1) && (m_presc == TD - 1);
    m_tick = tk;
    m_ovf  = tk && (m_live == 5999);
    if (lp) begin
      if (m_hold) m_hold = 0;
      else if (m_state == 1) begin
        m_snap = m_live;
        m_hold = 1;
      end
    end
    if (m_state == 1) m_presc = tk ? 0 : m_presc + 1;
    if (tk) m_live = (m_live + 1) % 6000;
    if (ss) m_state = (m_state == 1) ? 2 : 1;
  endtask

  // One clock cycle: drive pulses, predict, then compare after the edge.
  task automatic step(input bit ss = 0, input bit lp = 0, input bit clr = 0);
    logic [20:0] exp_v;
    start_stop = ss; lap = lp; clear = clr;
    model_step(ss, lp, clr);
    sb_q.push_back(model_out());
    @(posedge clk_in);
    #1;
    start_stop = 0; lap = 0; clear = 0;
    cyc++;
    exp_v = sb_q.pop_front();
    n_checks++;
    if (dut_out() !== exp_v) begin
      n_errors++;
      $display("FAIL scoreboard cyc=%0d got=%h exp=%h", cyc, dut_out(), exp_v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    reset = 1'b0;
    model_reset();
    n_checks++;
    if (dut_out() !== 21'h0) begin
      n_errors++;
      $display("FAIL reset_state got=%h exp=0", dut_out());
    end
    repeat (3) step();
  endtask

  task automatic test_run();
    step(1);
    n_checks++;
    if (running !== 1'b1) begin
      n_errors++;
      $display("FAIL run_start running got=%b exp=1", running);
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      n_checks++;
      if (tick !== (i % 4 == 0)) begin
        n_errors++;
        $display("FAIL run_tick i=%0d got=%b exp=%b", i, tick, (i % 4 == 0));
      end
      if (i == 4 || i == 8) begin
        n_checks++;
        if (disp_tenths !== 4'(i / 4)) begin
          n_errors++;
          $display("FAIL run_tenths i=%0d got=%0d exp=%0d", i, disp_tenths, i / 4);
        end
      end
    end
  endtask

  task automatic test_pause();
    step(0, 0, 1);
    step(1);
    repeat (5) step();
    step(1);
    repeat (20) step();
    n_checks++;
    if (paused !== 1'b1 || disp_tenths !== 4'd1 || tick !== 1'b0) begin
      n_errors++;
      $display("FAIL pause_hold got paused=%b tenths=%0d tick=%b exp 1,1,0",
               paused, disp_tenths, tick);
    end
    step(1);
    step();
    n_checks++;
    if (disp_tenths !== 4'd1) begin
      n_errors++;
      $display("FAIL resume_early got=%0d exp=1", disp_tenths);
    end
    step();
    n_checks++;
    if (disp_tenths !== 4'd2 || tick !== 1'b1) begin
      n_errors++;
      $display("FAIL resume_tick got tenths=%0d tick=%b exp 2,1", disp_tenths, tick);
    end
  endtask

  task automatic test_lap();
    step(0, 0, 1);
    step(1);
    repeat (48) step();
    step(0, 1);
    n_checks++;
    if (lap_hold !== 1'b1 || disp_sec_ones !== 4'd1 || disp_tenths !== 4'd2) begin
      n_errors++;
      $display("FAIL lap_freeze got hold=%b %0d.%0d exp 1 1.2",
               lap_hold, disp_sec_ones, disp_tenths);
    end
    repeat (3) step();
    n_checks++;
    if (disp_tenths !== 4'd2) begin
      n_errors++;
      $display("FAIL lap_frozen got=%0d exp=2", disp_tenths);
    end
    repeat (5) step();
    step(0, 1);
    n_checks++;
    if (lap_hold !== 1'b0 || disp_sec_ones !== 4'd1 || disp_tenths !== 4'd4) begin
      n_errors++;
      $display("FAIL lap_release got hold=%b %0d.%0d exp 0 1.4",
               lap_hold, disp_sec_ones, disp_tenths);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 1);
    step(1);
    repeat (3) step();
    step(1);
    n_checks++;
    if (paused !== 1'b1 || tick !== 1'b1 || disp_tenths !== 4'd1) begin
      n_errors++;
      $display("FAIL tick_with_stop got paused=%b tick=%b tenths=%0d exp 1,1,1",
               paused, tick, disp_tenths);
    end
    step(1);
    step();
    step(1, 1);
    n_checks++;
    if (paused !== 1'b1 || lap_hold !== 1'b1) begin
      n_errors++;
      $display("FAIL lap_with_stop got paused=%b hold=%b exp 1,1", paused, lap_hold);
    end
    step(0, 1);
    n_checks++;
    if (lap_hold !== 1'b0) begin
      n_errors++;
      $display("FAIL lap_release_pause got=%b exp=0", lap_hold);
    end
    step(0, 1);
    n_checks++;
    if (lap_hold !== 1'b0) begin
      n_errors++;
      $display("FAIL lap_ignored_pause got=%b exp=0", lap_hold);
    end
  endtask

  task automatic test_clear_combo();
    step(0, 0, 1);
    step(1);
    repeat (100) step();
    step(0, 1);
    repeat (47) step();
    step(1, 0, 1);
    n_checks++;
    if (dut_out() !== 21'h0) begin
      n_errors++;
      $display("FAIL clear_combo got=%h exp=0", dut_out());
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 1);
    step(1);
    repeat (10) step();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (dut_out() !== 21'h0) begin
      n_errors++;
      $display("FAIL async_reset got=%h exp=0", dut_out());
    end
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    step(1);
    repeat (4) step();
    n_checks++;
    if (disp_tenths !== 4'd1 || disp_sec_ones !== 4'd0 || running !== 1'b1) begin
      n_errors++;
      $display("FAIL restart got tenths=%0d ones=%0d run=%b exp 1,0,1",
               disp_tenths, disp_sec_ones, running);
    end
  endtask

  task automatic test_random();
    step(0, 0, 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 39) == 0);
  endtask

  task automatic test_overflow();
    step(0, 0, 1);
    step(1);
    repeat (23996) step();
    n_checks++;
    if ({disp_min, disp_sec_tens, disp_sec_ones, disp_tenths} !== 16'h9599) begin
      n_errors++;
      $display("FAIL max_value got=%h exp=9599",
               {disp_min, disp_sec_tens, disp_sec_ones, disp_tenths});
    end
    repeat (4) step();
    n_checks++;
    if ({disp_min, disp_sec_tens, disp_sec_ones, disp_tenths} !== 16'h0 ||
        overflow !== 1'b1 || running !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap got=%h ovf=%b run=%b exp 0000,1,1",
               {disp_min, disp_sec_tens, disp_sec_ones, disp_tenths}, overflow, running);
    end
    step();
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_pulse got=%b exp=0", overflow);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run();
    test_pause();
    test_lap();
    test_back_to_back();
    test_clear_combo();
    test_async_reset();
    test_random();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
